noc_inject_arbiter: RTL
=======================

// Module: noc_inject_arbiter
// PURPOSE
//  Shares one network injection port between NUM_SRC local packet sources (traffic generators / node queues).
//  Round-robin arbitration feeds a single holding register. The register drives the network's i_data/i_data_val
//  and obeys the network's o_en valid/enable protocol, including the VOQ rule: valid is only asserted while enable is high.
//  One instance per network port. It sits between the NetEmulation node side and the network i_data/o_en pins.
// PARAMETERS
//  NUM_SRC        4    number of requesting sources (>=2)
//  TOKEN_PERIOD   8    cycles per injection token (used only with INJECT_RATE_LIMIT_EN)
//  TOKEN_MAX      4    token bucket depth, saturating (used only with INJECT_RATE_LIMIT_EN)
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  synchronous reset, active high
//  src_pkt      in   packet_t[NUM_SRC]  per-source packet; src_pkt[i].valid = request
//  src_grant    out  [NUM_SRC-1:0]      one-hot; src_pkt[i] consumed this cycle, source advances next cycle
//  net_data     out  packet_t           to network i_data
//  net_data_val out  1                  to network i_data_val
//  net_en       in   1                  from network o_en (1 = will accept this cycle)
//  busy         out  1                  holding register occupied
//  inj_count    out  32                 packets accepted by the network, wraps at 2^32
// BEHAVIOUR
//  - Reset values: full=0, net_data='0, net_data_val=0, src_grant=0, busy=0, inj_count=0, rr_ptr=0, tokens=TOKEN_MAX.
//  - States: EMPTY (full=0) and HOLD (full=1). busy=full.
//  - net_data_val = full & net_en, combinational. A transfer ("xfer") occurs when net_data_val=1.
//    Never assert valid while net_en=0.
//  - load_ok = ~full | xfer. This allows back-to-back injection: reload in the same cycle the held packet leaves.
//  - If load_ok and any src_pkt[i].valid, then:
//    grant the first valid source at or after rr_ptr, searching upward and wrapping at NUM_SRC-1 -> 0;
//    src_grant[winner]=1 (combinational, same cycle);
//    net_data <= src_pkt[winner]; full <= 1; rr_ptr <= winner+1 (wraps to 0).
//  - If xfer and no load: full <= 0. If neither: register and rr_ptr hold.
//  - net_data stays stable while full & ~net_en. A source's request may drop without a grant; no penalty.
//  - Latency: request in EMPTY -> net_data_val in the next cycle, provided net_en=1. Sustained throughput is 1 pkt/cycle.
//  - src_grant is never asserted when load_ok=0 or when the winner is invalid. At most one bit is set.
//  - inj_count increments by 1 on each xfer.
//  - rst mid-HOLD: the held packet is discarded, no grant is issued that cycle, and all state returns to reset values.
//  - Sources must hold src_pkt stable until granted. The arbiter does not latch requests.
// CONFIGURATION
//  INJECT_RATE_LIMIT_EN defined:
//   - Add a token bucket. A period counter runs 0..TOKEN_PERIOD-1; on wrap, tokens++ (saturating at TOKEN_MAX).
//   - A load requires tokens>0; each load consumes one token.
//   - A refill and a consume in the same cycle leave tokens unchanged.
//   - With tokens==0, no grants are issued. An already-held packet still transfers normally.
//  INJECT_RATE_LIMIT_EN undefined:
//   - No token or period logic; loads are limited only by load_ok.
//   - The port list is identical in both builds.
// TESTING
//  1. Reset, src 0..3 all valid, net_en=1:
//     -> grants 0,1,2,3,0 on consecutive cycles; net_data_val=1 from cycle 2; inj_count=4 after cycle 5.
//  2. Only src 2 valid, net_en=0 for 5 cycles:
//     -> one grant to src 2, busy=1, net_data_val=0 and net_data stable;
//     -> net_en=1 -> one xfer, inj_count=1.
//  3. HOLD with net_en=1 and src 1 valid:
//     -> same-cycle xfer plus grant to src 1, busy stays 1, no idle bubble.
//  4. rr_ptr=3, only src 0 and src 3 valid -> grant 3, then 0 (wrap-around).
//  5. rst asserted while busy=1 and net_en=0:
//     -> next cycle busy=0, net_data_val=0, inj_count=0, first post-reset grant goes to src 0.
//  6. INJECT_RATE_LIMIT_EN, TOKEN_PERIOD=8, TOKEN_MAX=4, all sources valid, net_en=1:
//     -> 4 back-to-back grants, then exactly 1 grant per 8 cycles.

Source files
------------

// File: rtl/noc_inject_arbiter.sv
// Round-robin injection arbiter: NUM_SRC sources share one holding register that drives a network port.
// Optional token-bucket rate limiting is enabled by defining INJECT_RATE_LIMIT_EN.
package noc_inject_pkg;
  typedef struct packed {
    logic        valid;
    logic [7:0]  dest;
    logic [15:0] payload;
  } packet_t;
endpackage

module noc_inject_arbiter
  import noc_inject_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int TOKEN_PERIOD = 8,
  parameter int TOKEN_MAX    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  packet_t            src_pkt [NUM_SRC],
  output logic [NUM_SRC-1:0] src_grant,
  output packet_t            net_data,
  output logic               net_data_val,
  input  logic               net_en,
  output logic               busy,
  output logic [31:0]        inj_count
);
  localparam int PW = $clog2(NUM_SRC);

  logic          full_q, full_d;
  packet_t       net_data_q, net_data_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]   inj_count_q, inj_count_d;

  logic          xfer, load_ok, load, tok_ok;
  logic          hi_found, lo_found;
  logic [PW-1:0] hi_idx, lo_idx, win_idx;
  logic          any_req;

  assign xfer    = full_q & net_en;
  assign load_ok = ~full_q | xfer;

  // Round-robin search: lowest valid index at/after rr_ptr, else lowest valid overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_pkt[i].valid) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end else begin
          hi_found = hi_found;
        end
      end else begin
        lo_found = lo_found;
      end
    end
  end

  assign any_req = lo_found;
  assign win_idx = hi_found ? hi_idx : lo_idx;
  assign load    = load_ok & any_req & tok_ok & ~rst;

`ifdef INJECT_RATE_LIMIT_EN
  localparam int TW = $clog2(TOKEN_MAX + 1);
  localparam int CW = $clog2(TOKEN_PERIOD + 1);

  logic [TW-1:0] tokens_q, tokens_d;
  logic [CW-1:0] period_q, period_d;
  logic          refill;

  assign tok_ok = (tokens_q != TW'(0));
  assign refill = (period_q == CW'(TOKEN_PERIOD - 1));

  // Token bucket: refill on period wrap, consume on load; both together cancel out.
  always_comb begin
    period_d = refill ? CW'(0) : period_q + CW'(1);
    if (refill && !load) begin
      tokens_d = (tokens_q == TW'(TOKEN_MAX)) ? tokens_q : tokens_q + TW'(1);
    end else if (load && !refill) begin
      tokens_d = tokens_q - TW'(1);
    end else begin
      tokens_d = tokens_q;
    end
  end

  // Token state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tokens_q <= TW'(TOKEN_MAX);
      period_q <= CW'(0);
    end else begin
      tokens_q <= tokens_d;
      period_q <= period_d;
    end
  end
`else
  assign tok_ok = 1'b1;
`endif

  // Next-state for the holding register, pointer and counter.
  always_comb begin
    net_data_d  = net_data_q;
    full_d      = full_q;
    rr_ptr_d    = rr_ptr_q;
    inj_count_d = xfer ? inj_count_q + 32'd1 : inj_count_q;
    if (load) begin
      net_data_d = src_pkt[win_idx];
      full_d     = 1'b1;
      rr_ptr_d   = (win_idx == PW'(NUM_SRC - 1)) ? PW'(0) : win_idx + PW'(1);
    end else if (xfer) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Holding register, round-robin pointer and injection counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 1'b0;
      net_data_q  <= '0;
      rr_ptr_q    <= '0;
      inj_count_q <= 32'd0;
    end else begin
      full_q      <= full_d;
      net_data_q  <= net_data_d;
      rr_ptr_q    <= rr_ptr_d;
      inj_count_q <= inj_count_d;
    end
  end

  // One-hot grant, issued only on an actual load.
  always_comb begin
    src_grant = '0;
    if (load) begin
      src_grant[win_idx] = 1'b1;
    end else begin
      src_grant = '0;
    end
  end

  assign net_data     = net_data_q;
  assign net_data_val = xfer;
  assign busy         = full_q;
  assign inj_count    = inj_count_q;
endmodule
